// File: rtl/multdiv_scheduler_if.sv
// Handshake bundle between the pipeline control and the multdiv scheduler.
// The pipeline side uses the master modport; the scheduler uses slave.
interface multdiv_scheduler_if;
   logic       start_mult;
   logic       start_div;
   logic [4:0] dx_rd;
   logic [4:0] fd_rs;
   logic [4:0] fd_rt;
   logic       md_ready;
   logic       md_exception;
   logic       mw_regfile_we;
   logic       ctrl_MULT;
   logic       ctrl_DIV;
   logic       busy;
   logic       stall;
   logic       wb_en;
   logic [4:0] wb_rd;
   logic       wb_exception;
   logic       timeout;

   modport master (
      output start_mult, start_div, dx_rd, fd_rs, fd_rt,
             md_ready, md_exception, mw_regfile_we,
      input  ctrl_MULT, ctrl_DIV, busy, stall, wb_en, wb_rd,
             wb_exception, timeout
   );

   modport slave (
      input  start_mult, start_div, dx_rd, fd_rs, fd_rt,
             md_ready, md_exception, mw_regfile_we,
      output ctrl_MULT, ctrl_DIV, busy, stall, wb_en, wb_rd,
             wb_exception, timeout
   );
endinterface

// File: rtl/multdiv_scheduler.sv
// Multdiv scheduler: launches a multiply/divide, waits for the result with a
// timeout, and writes the result back through the PW port when MW leaves the
// register file free. Generates the pipeline stall for busy/hazard cases.
module multdiv_scheduler #(
   parameter int unsigned TIMEOUT_CYCLES = 40
) (
   input logic                clock,
   input logic                reset,
   multdiv_scheduler_if.slave bus
);

   localparam int unsigned    CW       = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      WRITEBACK
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [CW-1:0] cnt;
   logic [4:0]    rd_q;
   logic          exc_q;
   logic          mult_q;
   logic          div_q;
   logic          start_any;
   logic          busy_w;
   logic          wb_fire;
   logic          hazard;

   assign start_any = bus.start_mult | bus.start_div;

   // State register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state decode
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:      if (start_any) state_nxt = RUN;
         RUN: begin
            if (bus.md_ready)          state_nxt = WRITEBACK;
            else if (cnt == CNT_LAST)  state_nxt = IDLE;
         end
         WRITEBACK: if (!bus.mw_regfile_we) state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   // Operation datapath: capture on accept, count in RUN, latch exception
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt    <= '0;
         rd_q   <= '0;
         exc_q  <= 1'b0;
         mult_q <= 1'b0;
         div_q  <= 1'b0;
      end else begin
         mult_q <= 1'b0;
         div_q  <= 1'b0;
         case (state)
            IDLE: begin
               if (start_any) begin
                  rd_q   <= bus.dx_rd;
                  cnt    <= '0;
                  // mult wins when both decode in the same cycle
                  mult_q <= bus.start_mult;
                  div_q  <= ~bus.start_mult;
               end
            end
            RUN: begin
               if (cnt != '1)    cnt   <= cnt + 1'b1;
               if (bus.md_ready) exc_q <= bus.md_exception;
            end
            default: ;
         endcase
      end
   end

   // Outputs: status, write-back port and stall
   always_comb begin
      busy_w  = (state != IDLE);
      wb_fire = (state == WRITEBACK) && !bus.mw_regfile_we;
      hazard  = (rd_q != 5'd0) && ((bus.fd_rs == rd_q) || (bus.fd_rt == rd_q));
      bus.busy         = busy_w;
      bus.wb_en        = wb_fire;
      bus.wb_exception = wb_fire & exc_q;
      bus.timeout      = (state == RUN) && !bus.md_ready && (cnt == CNT_LAST);
      // the hazard term drops in the write cycle so the consumer decodes
      // right after the register file has been updated
      bus.stall        = busy_w & (start_any | (hazard & ~wb_fire));
      bus.wb_rd        = rd_q;
      bus.ctrl_MULT    = mult_q;
      bus.ctrl_DIV     = div_q;
   end

endmodule

// File: tb/tb_multdiv_scheduler.sv
// Self-checking bench for multdiv_scheduler (TIMEOUT_CYCLES = 8).
module tb_multdiv_scheduler;

   logic clock = 1'b0;
   logic reset = 1'b0;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   int unsigned mult_cnt = 0;
   int unsigned div_cnt  = 0;
   int unsigned wb_cnt   = 0;
   int unsigned to_cnt   = 0;

   typedef struct packed {
      logic [4:0] rd;
      logic       exc;
   } wb_t;

   wb_t exp_q[$];

   multdiv_scheduler_if bus();

   multdiv_scheduler #(.TIMEOUT_CYCLES(8)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   // Monitor: pops the scoreboard on every write-back, tallies pulses
   always @(negedge clock) begin
      if (bus.wb_en) begin
         wb_cnt++;
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL wb_unexpected: wb_en=1 rd=%0d with no write-back expected", bus.wb_rd);
         end else begin
            wb_t e;
            e = exp_q.pop_front();
            if ({bus.wb_rd, bus.wb_exception} !== e) begin
               n_fail++;
               $display("FAIL wb_data: got rd=%0d exc=%b expected rd=%0d exc=%b",
                        bus.wb_rd, bus.wb_exception, e.rd, e.exc);
            end
         end
      end
      if (bus.ctrl_MULT) mult_cnt++;
      if (bus.ctrl_DIV)  div_cnt++;
      if (bus.timeout)   to_cnt++;
      if (bus.ctrl_MULT || bus.ctrl_DIV) begin
         n_checks++;
         if (bus.ctrl_MULT && bus.ctrl_DIV) begin
            n_fail++;
            $display("FAIL ctrl_exclusive: got MULT=%b DIV=%b expected at most one", bus.ctrl_MULT, bus.ctrl_DIV);
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic clear_inputs();
      bus.start_mult    = 1'b0;
      bus.start_div     = 1'b0;
      bus.dx_rd         = 5'd0;
      bus.fd_rs         = 5'd0;
      bus.fd_rt         = 5'd0;
      bus.md_ready      = 1'b0;
      bus.md_exception  = 1'b0;
      bus.mw_regfile_we = 1'b0;
   endtask

   task automatic test_reset();
      clear_inputs();
      reset = 1'b0;
      bus.start_mult = 1'b1;
      bus.dx_rd = 5'd9;
      repeat (2) tick();
      n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
      n_checks++; if ({bus.ctrl_MULT, bus.ctrl_DIV} !== 2'b00) begin n_fail++; $display("FAIL reset_ctrl: got %b expected 00", {bus.ctrl_MULT, bus.ctrl_DIV}); end
      n_checks++; if ({bus.wb_en, bus.wb_exception, bus.timeout} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b expected 000", {bus.wb_en, bus.wb_exception, bus.timeout}); end
      n_checks++; if (bus.wb_rd !== 5'd0) begin n_fail++; $display("FAIL reset_wb_rd: got %0d expected 0", bus.wb_rd); end
      n_checks++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", bus.stall); end
      clear_inputs();
      reset = 1'b1;
      tick();
      n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_release_idle: got %b expected 0", bus.busy); end
   endtask

   task automatic test_mult();
      int unsigned m0, w0;
      m0 = mult_cnt; w0 = wb_cnt;
      bus.start_mult = 1'b1; bus.dx_rd = 5'd5;
      tick();
      bus.start_mult = 1'b0; bus.dx_rd = 5'd0;
      @(negedge clock);
      n_checks++; if ({bus.ctrl_MULT, bus.ctrl_DIV} !== 2'b10) begin n_fail++; $display("FAIL mult_ctrl: got %b expected 10", {bus.ctrl_MULT, bus.ctrl_DIV}); end
      n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL mult_busy: got %b expected 1", bus.busy); end
      n_checks++; if (bus.wb_rd !== 5'd5) begin n_fail++; $display("FAIL mult_wb_rd: got %0d expected 5", bus.wb_rd); end
      tick();
      @(negedge clock);
      n_checks++; if (bus.ctrl_MULT !== 1'b0) begin n_fail++; $display("FAIL mult_ctrl_single: got %b expected 0", bus.ctrl_MULT); end
      repeat (2) tick();
      bus.md_ready = 1'b1; bus.md_exception = 1'b0;
      exp_q.push_back('{rd: 5'd5, exc: 1'b0});
      tick();
      bus.md_ready = 1'b0;
      @(negedge clock);
      n_checks++; if (bus.wb_en !== 1'b1) begin n_fail++; $display("FAIL mult_wb_latency: got %b expected 1", bus.wb_en); end
      tick();
      @(negedge clock);
      n_checks++; if ({bus.busy, bus.wb_en} !== 2'b00) begin n_fail++; $display("FAIL mult_done: got busy,wb_en=%b expected 00", {bus.busy, bus.wb_en}); end
      n_checks++; if (mult_cnt - m0 !== 1) begin n_fail++; $display("FAIL mult_pulses: got %0d expected 1", mult_cnt - m0); end
      n_checks++; if (wb_cnt - w0 !== 1) begin n_fail++; $display("FAIL mult_wb_count: got %0d expected 1", wb_cnt - w0); end
   endtask

   task automatic test_hazard();
      bus.start_div = 1'b1; bus.dx_rd = 5'd5; bus.fd_rt = 5'd5;
      #1;
      n_checks++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL hazard_idle_stall: got %b expected 0", bus.stall); end
      tick();
      bus.start_div = 1'b0; bus.dx_rd = 5'd0;
      @(negedge clock);
      n_checks++; if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL hazard_stall_run: got %b expected 1", bus.stall); end
      n_checks++; if (bus.ctrl_DIV !== 1'b1) begin n_fail++; $display("FAIL hazard_ctrl_div: got %b expected 1", bus.ctrl_DIV); end
      bus.fd_rt = 5'd0; bus.fd_rs = 5'd0;
      #1;
      n_checks++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL hazard_no_dep: got %b expected 0", bus.stall); end
      bus.fd_rt = 5'd5;
      tick();
      bus.md_ready = 1'b1; bus.md_exception = 1'b1;
      exp_q.push_back('{rd: 5'd5, exc: 1'b1});
      @(negedge clock);
      n_checks++; if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL hazard_stall_before_wb: got %b expected 1", bus.stall); end
      tick();
      bus.md_ready = 1'b0; bus.md_exception = 1'b0;
      @(negedge clock);
      n_checks++; if ({bus.wb_en, bus.stall} !== 2'b10) begin n_fail++; $display("FAIL hazard_release: got wb_en,stall=%b expected 10", {bus.wb_en, bus.stall}); end
      tick();
      bus.fd_rt = 5'd0;
      @(negedge clock);
      n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL hazard_done: got %b expected 0", bus.busy); end
   endtask

   task automatic test_r0();
      int unsigned w0;
      w0 = wb_cnt;
      bus.start_mult = 1'b1; bus.dx_rd = 5'd0;
      tick();
      bus.start_mult = 1'b0;
      @(negedge clock);
      n_checks++; if ({bus.busy, bus.stall} !== 2'b10) begin n_fail++; $display("FAIL r0_no_stall: got busy,stall=%b expected 10", {bus.busy, bus.stall}); end
      bus.md_ready = 1'b1;
      exp_q.push_back('{rd: 5'd0, exc: 1'b0});
      tick();
      bus.md_ready = 1'b0;
      tick();
      @(negedge clock);
      n_checks++; if (wb_cnt - w0 !== 1) begin n_fail++; $display("FAIL r0_wb: got %0d expected 1", wb_cnt - w0); end
   endtask

   task automatic test_mw_priority();
      int unsigned w0;
      w0 = wb_cnt;
      bus.start_mult = 1'b1; bus.dx_rd = 5'd7;
      tick();
      bus.start_mult = 1'b0;
      tick();
      bus.md_ready = 1'b1; bus.mw_regfile_we = 1'b1;
      exp_q.push_back('{rd: 5'd7, exc: 1'b0});
      tick();
      bus.md_ready = 1'b0;
      @(negedge clock);
      n_checks++; if ({bus.wb_en, bus.busy} !== 2'b01) begin n_fail++; $display("FAIL mw_hold1: got wb_en,busy=%b expected 01", {bus.wb_en, bus.busy}); end
      tick();
      @(negedge clock);
      n_checks++; if (bus.wb_en !== 1'b0) begin n_fail++; $display("FAIL mw_hold2: got %b expected 0", bus.wb_en); end
      tick();
      bus.mw_regfile_we = 1'b0;
      @(negedge clock);
      n_checks++; if (bus.wb_en !== 1'b1) begin n_fail++; $display("FAIL mw_release: got %b expected 1", bus.wb_en); end
      tick();
      @(negedge clock);
      n_checks++; if ({bus.wb_en, bus.busy} !== 2'b00) begin n_fail++; $display("FAIL mw_done: got wb_en,busy=%b expected 00", {bus.wb_en, bus.busy}); end
      n_checks++; if (wb_cnt - w0 !== 1) begin n_fail++; $display("FAIL mw_single: got %0d expected 1", wb_cnt - w0); end
   endtask

   task automatic test_timeout();
      int unsigned w0, t0;
      w0 = wb_cnt; t0 = to_cnt;
      bus.start_div = 1'b1; bus.dx_rd = 5'd9;
      tick();
      bus.start_div = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clock);
         n_checks++;
         if (bus.timeout !== (k == 8)) begin
            n_fail++;
            $display("FAIL timeout_cycle%0d: got %b expected %b", k, bus.timeout, (k == 8));
         end
         tick();
      end
      @(negedge clock);
      n_checks++; if ({bus.busy, bus.timeout, bus.wb_en} !== 3'b000) begin n_fail++; $display("FAIL timeout_idle: got busy,timeout,wb_en=%b expected 000", {bus.busy, bus.timeout, bus.wb_en}); end
      bus.md_ready = 1'b1;
      tick();
      bus.md_ready = 1'b0;
      @(negedge clock);
      n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL timeout_late_ready: got busy=%b expected 0", bus.busy); end
      n_checks++; if (to_cnt - t0 !== 1) begin n_fail++; $display("FAIL timeout_pulses: got %0d expected 1", to_cnt - t0); end
      n_checks++; if (wb_cnt - w0 !== 0) begin n_fail++; $display("FAIL timeout_no_wb: got %0d expected 0", wb_cnt - w0); end
   endtask

   task automatic test_ready_wins();
      int unsigned t0;
      t0 = to_cnt;
      bus.start_mult = 1'b1; bus.dx_rd = 5'd11;
      tick();
      bus.start_mult = 1'b0;
      repeat (7) tick();
      bus.md_ready = 1'b1; bus.md_exception = 1'b1;
      exp_q.push_back('{rd: 5'd11, exc: 1'b1});
      @(negedge clock);
      n_checks++; if ({bus.timeout, bus.busy} !== 2'b01) begin n_fail++; $display("FAIL ready_wins_timeout: got timeout,busy=%b expected 01", {bus.timeout, bus.busy}); end
      tick();
      bus.md_ready = 1'b0; bus.md_exception = 1'b0;
      @(negedge clock);
      n_checks++; if (bus.wb_en !== 1'b1) begin n_fail++; $display("FAIL ready_wins_wb: got %b expected 1", bus.wb_en); end
      tick();
      n_checks++; if (to_cnt - t0 !== 0) begin n_fail++; $display("FAIL ready_wins_pulses: got %0d expected 0", to_cnt - t0); end
   endtask

   task automatic test_back_to_back();
      int unsigned d0;
      d0 = div_cnt;
      bus.start_mult = 1'b1; bus.dx_rd = 5'd3;
      tick();
      bus.start_mult = 1'b0;
      bus.start_div = 1'b1; bus.dx_rd = 5'd4;
      @(negedge clock);
      n_checks++; if ({bus.stall, bus.ctrl_DIV} !== 2'b10) begin n_fail++; $display("FAIL b2b_held: got stall,ctrl_DIV=%b expected 10", {bus.stall, bus.ctrl_DIV}); end
      bus.md_ready = 1'b1;
      exp_q.push_back('{rd: 5'd3, exc: 1'b0});
      tick();
      bus.md_ready = 1'b0;
      @(negedge clock);
      n_checks++; if ({bus.wb_en, bus.stall, bus.ctrl_DIV} !== 3'b110) begin n_fail++; $display("FAIL b2b_wb_cycle: got wb_en,stall,ctrl_DIV=%b expected 110", {bus.wb_en, bus.stall, bus.ctrl_DIV}); end
      tick();
      @(negedge clock);
      n_checks++; if ({bus.busy, bus.stall, bus.ctrl_DIV} !== 3'b000) begin n_fail++; $display("FAIL b2b_idle: got busy,stall,ctrl_DIV=%b expected 000", {bus.busy, bus.stall, bus.ctrl_DIV}); end
      tick();
      bus.start_div = 1'b0; bus.dx_rd = 5'd0;
      @(negedge clock);
      n_checks++; if ({bus.ctrl_DIV, bus.wb_rd} !== {1'b1, 5'd4}) begin n_fail++; $display("FAIL b2b_accept: got ctrl_DIV=%b rd=%0d expected 1 rd=4", bus.ctrl_DIV, bus.wb_rd); end
      bus.md_ready = 1'b1;
      exp_q.push_back('{rd: 5'd4, exc: 1'b0});
      tick();
      bus.md_ready = 1'b0;
      repeat (2) tick();
      n_checks++; if (div_cnt - d0 !== 1) begin n_fail++; $display("FAIL b2b_div_pulses: got %0d expected 1", div_cnt - d0); end
   endtask

   task automatic test_reset_mid();
      int unsigned w0, m0, d0;
      w0 = wb_cnt;
      bus.start_mult = 1'b1; bus.dx_rd = 5'd6;
      tick();
      bus.start_mult = 1'b0; bus.fd_rs = 5'd6;
      tick();
      #2;
      reset = 1'b0;
      #1;
      n_checks++; if ({bus.busy, bus.stall, bus.ctrl_MULT, bus.ctrl_DIV, bus.wb_en, bus.timeout} !== 6'b0) begin n_fail++; $display("FAIL midreset_outputs: got %b expected 000000", {bus.busy, bus.stall, bus.ctrl_MULT, bus.ctrl_DIV, bus.wb_en, bus.timeout}); end
      n_checks++; if (bus.wb_rd !== 5'd0) begin n_fail++; $display("FAIL midreset_wb_rd: got %0d expected 0", bus.wb_rd); end
      bus.md_ready = 1'b1;
      tick();
      reset = 1'b1;
      tick();
      bus.md_ready = 1'b0; bus.fd_rs = 5'd0;
      @(negedge clock);
      n_checks++; if ({bus.busy, bus.wb_en} !== 2'b00) begin n_fail++; $display("FAIL midreset_ignored: got busy,wb_en=%b expected 00", {bus.busy, bus.wb_en}); end
      n_checks++; if (wb_cnt - w0 !== 0) begin n_fail++; $display("FAIL midreset_no_wb: got %0d expected 0", wb_cnt - w0); end
      m0 = mult_cnt; d0 = div_cnt;
      bus.start_mult = 1'b1; bus.start_div = 1'b1; bus.dx_rd = 5'd2;
      tick();
      bus.start_mult = 1'b0; bus.start_div = 1'b0; bus.dx_rd = 5'd0;
      @(negedge clock);
      n_checks++; if ({bus.ctrl_MULT, bus.ctrl_DIV} !== 2'b10) begin n_fail++; $display("FAIL both_starts: got MULT,DIV=%b expected 10", {bus.ctrl_MULT, bus.ctrl_DIV}); end
      bus.md_ready = 1'b1;
      exp_q.push_back('{rd: 5'd2, exc: 1'b0});
      tick();
      bus.md_ready = 1'b0;
      repeat (2) tick();
      n_checks++; if ((mult_cnt - m0 !== 1) || (div_cnt - d0 !== 0)) begin n_fail++; $display("FAIL both_pulses: got mult=%0d div=%0d expected mult=1 div=0", mult_cnt - m0, div_cnt - d0); end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_mult();
      test_hazard();
      test_r0();
      test_mw_priority();
      test_timeout();
      test_ready_wins();
      test_back_to_back();
      test_reset_mid();
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d pending write-backs expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
